// File: rtl/hex_pattern_decoder.sv
// rtl/hex_pattern_decoder.sv - snapshots six 7-segment patterns and streams decoded digits
module hex_pattern_decoder #(
    parameter bit SKIP_BLANK = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [7:0] HEX0,
    input  logic [7:0] HEX1,
    input  logic [7:0] HEX2,
    input  logic [7:0] HEX3,
    input  logic [7:0] HEX4,
    input  logic [7:0] HEX5,
    output logic       BUSY,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [2:0] OUT_INDEX,
    output logic [3:0] OUT_DIGIT,
    output logic       OUT_DP,
    output logic       OUT_BLANK,
    output logic       OUT_ERR,
    output logic       DONE,
    output logic [2:0] ERR_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hex_live [6];
    logic [7:0] cap_q [6];
    logic [7:0] cap_d [6];
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [3:0] digit_q, digit_d;
    logic       dp_q, dp_d;
    logic       blank_q, blank_d;
    logic       err_q, err_d;
    logic [2:0] errcnt_q, errcnt_d;

    logic       capture;
    logic       load;
    logic       finish;
    logic [7:0] sel_pat;
    logic [6:0] seg;
    logic [3:0] dec_digit;
    logic       dec_blank;
    logic       dec_err;

    assign hex_live[0] = HEX0;
    assign hex_live[1] = HEX1;
    assign hex_live[2] = HEX2;
    assign hex_live[3] = HEX3;
    assign hex_live[4] = HEX4;
    assign hex_live[5] = HEX5;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    capture = 1'b1;
                    load    = 1'b1;
                    idx_d   = 3'd0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // a skipped blank (valid low) advances unconditionally
                if (!valid_q || OUT_READY) begin
                    if (idx_q == 3'd5) begin
                        finish  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        load  = 1'b1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The decoder looks at next-cycle data so the beat can be registered with no extra latency.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            cap_d[i] = capture ? hex_live[i] : cap_q[i];
        end
        case (idx_d)
            3'd1:    sel_pat = cap_d[1];
            3'd2:    sel_pat = cap_d[2];
            3'd3:    sel_pat = cap_d[3];
            3'd4:    sel_pat = cap_d[4];
            3'd5:    sel_pat = cap_d[5];
            default: sel_pat = cap_d[0];
        endcase
    end

    // segment a in the MSB so the literals below read in a..g order
    assign seg = {sel_pat[0], sel_pat[1], sel_pat[2], sel_pat[3],
                  sel_pat[4], sel_pat[5], sel_pat[6]};

    always_comb begin
        dec_digit = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg)
            7'b0000001: dec_digit = 4'h0;
            7'b1001111: dec_digit = 4'h1;
            7'b0010010: dec_digit = 4'h2;
            7'b0000110: dec_digit = 4'h3;
            7'b1001100: dec_digit = 4'h4;
            7'b0100100: dec_digit = 4'h5;
            7'b0100000: dec_digit = 4'h6;
            7'b0001111: dec_digit = 4'h7;
            7'b0000000: dec_digit = 4'h8;
            7'b0000100: dec_digit = 4'h9;
            7'b0001000: dec_digit = 4'hA;
            7'b1100000: dec_digit = 4'hB;
            7'b0110001: dec_digit = 4'hC;
            7'b1000010: dec_digit = 4'hD;
            7'b0110000: dec_digit = 4'hE;
            7'b0111000: dec_digit = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        digit_d  = digit_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;
        if (load) begin
            valid_d  = !(SKIP_BLANK && dec_blank);
            digit_d  = dec_digit;
            dp_d     = ~sel_pat[7];
            blank_d  = dec_blank;
            err_d    = dec_err;
            errcnt_d = (capture ? 3'd0 : errcnt_q) + {2'b00, dec_err};
        end else if (finish) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            valid_q  <= 1'b0;
            digit_q  <= 4'h0;
            dp_q     <= 1'b0;
            blank_q  <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                cap_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            digit_q  <= digit_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            for (int i = 0; i < 6; i++) begin
                cap_q[i] <= cap_d[i];
            end
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FIN);
    assign OUT_VALID = valid_q;
    assign OUT_INDEX = idx_q;
    assign OUT_DIGIT = digit_q;
    assign OUT_DP    = dp_q;
    assign OUT_BLANK = blank_q;
    assign OUT_ERR   = err_q;
    assign ERR_COUNT = errcnt_q;

endmodule

// File: doc/hex_pattern_decoder.md
# hex_pattern_decoder

Reads back the six active-low seven-segment buses that drive HEX0–HEX5 and recovers the hexadecimal digit each one shows. It is the receive end of the switch-to-display path. A START pulse snapshots all six patterns; the block then streams one decoded digit per transfer over a valid/ready handshake, flags blank and illegal patterns, and pulses DONE at the end of the frame. Intended consumers are self-check logic and a UART/debug reporter.

## Interface
- SKIP_BLANK, default 0: when 1, blank digits produce no output beat.
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle request to capture and decode a frame.
- HEX0..HEX5  in  8 each, [0:7]  segment patterns, active-low. Bit order: 0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g, 7=dp.
- BUSY  out  1  high from the capture edge through the DONE cycle.
- OUT_VALID  out  1  a decoded beat is present.
- OUT_READY  in  1  the consumer accepts the beat.
- OUT_INDEX  out  3  source digit number, 0–5.
- OUT_DIGIT  out  4  decoded value, 0x0–0xF.
- OUT_DP  out  1  high when the dp segment is lit (bit 7 = 0).
- OUT_BLANK  out  1  segments a–g are all off.
- OUT_ERR  out  1  the a–g pattern is not in the legal set.
- DONE  out  1  one-cycle pulse after the last digit.
- ERR_COUNT  out  3  number of illegal patterns in the last frame.

## Operation
- Legal a–g patterns, bits 0..6:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Blank is 1111111.
- The dp bit never affects digit, blank or error classification.
- Blank and illegal patterns give OUT_DIGIT=0. Illegal patterns give OUT_ERR=1. OUT_BLANK and OUT_ERR are never high together.
- A single shared decoder operates on the captured pattern selected by the index counter. The live HEX inputs are not used after capture.
- FSM states:
  - IDLE: START=1 latches HEX0..HEX5, clears the index and ERR_COUNT, and moves to DECODE.
  - DECODE: presents the beat for the current index. The beat advances on OUT_VALID&&OUT_READY. After index 5 is transferred, the FSM moves to FIN.
  - FIN: DONE=1 for one cycle, then IDLE.
- SKIP_BLANK=1: a blank index occupies one DECODE cycle with OUT_VALID=0, then the index advances.
- ERR_COUNT increments once per illegal digit, when that digit is evaluated. It holds its value until the next capture.
- START is ignored while BUSY=1.

## Timing
- Reset values: BUSY, OUT_VALID, DONE, OUT_INDEX, OUT_DIGIT, OUT_DP, OUT_BLANK, OUT_ERR and ERR_COUNT are all 0. State is IDLE.
- Reset asserted mid-frame aborts immediately. There is no DONE pulse and the captured data is discarded.
- START sampled high at edge k:
  - BUSY=1 and OUT_VALID=1 for index 0 after edge k.
  - This is a 1-cycle latency to the first beat.
- All beat outputs are registered and remain stable while OUT_VALID=1 and OUT_READY=0.
- With OUT_READY held high, one beat transfers per cycle. A full frame takes 6 beat cycles plus 1 FIN cycle, so BUSY is high for 7 cycles.
- DONE is asserted in the cycle after the index-5 transfer (or the skip cycle). BUSY falls together with DONE, on the following edge.
- A START arriving in the FIN cycle is ignored. A START in the first IDLE cycle afterwards is accepted.
- HEX inputs that change after the capture edge do not affect the frame in progress.

## Test plan
- **Reset values:** hold RESET_N=0 → all outputs 0. Release, idle 5 cycles → no beats.
- **Straight frame:**
  - Stimulus: HEX0=10011111, HEX1=00000011, HEX2..HEX5=00000001, START pulse, OUT_READY=1.
  - Required: beats (0,1), (1,0), (2,8)…(5,8) on consecutive cycles; DONE one cycle after the last beat; ERR_COUNT=0.
- **Backpressure:** same frame with OUT_READY low for 3 cycles on index 2 → index 2 beat held stable for 4 cycles with no loss; total BUSY = 10 cycles.
- **Errors and dp:**
  - Stimulus: HEX3=11111110, HEX4=01010101.
  - Required: index 3 beat has OUT_BLANK=1, OUT_DP=1. Index 4 beat has OUT_ERR=1, OUT_DIGIT=0. ERR_COUNT=1 after DONE.
- **SKIP_BLANK=1:** all six inputs = 11111111 → zero beats, DONE seven cycles after START.
- **Abort and STARTs:**
  - RESET_N low while on index 3 → all outputs 0 immediately; the next START restarts at index 0.
  - A START mid-frame has no effect.
